// File: rtl/mux_nx1_reg_if.sv
// Channel-side and output-side handshake bundle for mux_nx1_reg.
// master drives the channels and downstream ready; slave is the mux itself.
interface mux_nx1_reg_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NCH   = 4
);
  localparam int unsigned SELW = $clog2(NCH);

  logic [NCH*WIDTH-1:0] i;
  logic [NCH-1:0]       iv;
  logic [NCH-1:0]       ir;
  logic [SELW-1:0]      sel;
  logic [WIDTH-1:0]     q;
  logic                 qv;
  logic                 qr;
  logic [SELW-1:0]      qch;

  modport master (
    output i, iv, sel, qr,
    input  ir, q, qv, qch
  );

  modport slave (
    input  i, iv, sel, qr,
    output ir, q, qv, qch
  );
endinterface

// File: rtl/mux_nx1_reg.sv
// N:1 channel mux feeding a single registered output slot with valid/ready flow control.
// Define MUX_RR_EN for round-robin arbitration; otherwise the channel is chosen by sel.
module mux_nx1_reg #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NCH   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  mux_nx1_reg_if.slave bus
);
  localparam int unsigned SELW = $clog2(NCH);

  logic [NCH-1:0][WIDTH-1:0] ch_data;
  logic [WIDTH-1:0]          q_q;
  logic [SELW-1:0]           qch_q;
  logic                      qv_q;
  logic                      can_load;
  logic                      gnt_vld;
  logic [SELW-1:0]           gnt;
  logic [NCH-1:0]            ir;
  logic                      load;

  assign ch_data  = bus.i;
  assign can_load = ~qv_q | bus.qr;

`ifdef MUX_RR_EN
  logic [SELW-1:0] ptr_q;
  logic [SELW-1:0] idx;
  logic            unused_sel;

  assign unused_sel = ^bus.sel;

  // First requesting channel at or after ptr; NCH is a power of two so the index wraps for free.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = ptr_q;
    idx     = '0;
    for (int j = 0; j < int'(NCH); j++) begin
      idx = ptr_q + SELW'(j);
      if (!gnt_vld && bus.iv[idx]) begin
        gnt_vld = 1'b1;
        gnt     = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (load) begin
      ptr_q <= gnt + 1'b1;
    end
  end
`else
  assign gnt_vld = 1'b1;
  assign gnt     = bus.sel;
`endif

  // Ready is suppressed during reset so nothing can be accepted while the slot is cleared.
  always_comb begin
    ir = '0;
    if (rst_n && gnt_vld && can_load) begin
      ir[gnt] = 1'b1;
    end
  end

  assign load = bus.iv[gnt] & ir[gnt];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q   <= '0;
      qch_q <= '0;
      qv_q  <= 1'b0;
    end else if (load) begin
      q_q   <= ch_data[gnt];
      qch_q <= gnt;
      qv_q  <= 1'b1;
    end else if (qv_q && bus.qr) begin
      qv_q  <= 1'b0;
    end
  end

  assign bus.ir  = ir;
  assign bus.q   = q_q;
  assign bus.qv  = qv_q;
  assign bus.qch = qch_q;

  ir_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.ir));

endmodule

// File: tb/tb_mux_nx1_reg.sv
// Self-checking bench for mux_nx1_reg: directed vector table, corner sequences, and a
// randomized run against a slot/scoreboard reference model.
module tb_mux_nx1_reg;
  localparam int WIDTH = 16;
  localparam int NCH   = 4;
  localparam int SELW  = $clog2(NCH);

  logic clk;
  logic rst_n;

  logic [NCH-1:0][WIDTH-1:0] din;
  logic [NCH-1:0]            iv;
  logic [SELW-1:0]           sel;
  logic                      qr;

  mux_nx1_reg_if #(.WIDTH(WIDTH), .NCH(NCH)) bus ();

  assign bus.i   = din;
  assign bus.iv  = iv;
  assign bus.sel = sel;
  assign bus.qr  = qr;

  mux_nx1_reg #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: one slot plus a queue of accepted words awaiting delivery.
  logic             m_qv;
  logic [WIDTH-1:0] m_q;
  logic [SELW-1:0]  m_qch;
`ifdef MUX_RR_EN
  int               m_ptr;
`endif
  logic [WIDTH-1:0] sb[$];
  logic [NCH-1:0]   seen_ir;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    m_qv  = 1'b0;
    m_q   = '0;
    m_qch = '0;
`ifdef MUX_RR_EN
    m_ptr = 0;
`endif
    sb.delete();
  endtask

  task automatic drive(input logic [NCH-1:0] v, input logic [SELW-1:0] s, input logic r,
                       input logic [WIDTH-1:0] d);
    iv  = v;
    sel = s;
    qr  = r;
    for (int k = 0; k < NCH; k++) din[k] = WIDTH'(16'h0F00 + k);
    din[s] = d;
  endtask

  // One clock: check outputs against the model mid-cycle, advance the model, return at edge+1.
  task automatic step();
    logic [NCH-1:0] e_ir;
    logic           can;
    logic           g_ok;
    logic           xfer;
    int             g;
    int             k;
    @(negedge clk);
    can = !m_qv || qr;
`ifdef MUX_RR_EN
    g_ok = 1'b0;
    g    = 0;
    for (int j = 0; j < NCH; j++) begin
      k = (m_ptr + j) % NCH;
      if (!g_ok && iv[k]) begin
        g_ok = 1'b1;
        g    = k;
      end
    end
`else
    k    = 0;
    g_ok = 1'b1;
    g    = int'(sel);
`endif
    e_ir = '0;
    if (g_ok && can) e_ir[g] = 1'b1;
    xfer = g_ok && can && iv[g];
    seen_ir = bus.ir;
    check("ir", bus.ir, e_ir);
    check("qv", bus.qv, m_qv);
    check("q", bus.q, m_q);
    check("qch", bus.qch, m_qch);
    if (bus.qv && qr) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_empty actual=delivery required=none at %0t", $time);
      end else begin
        check("sb_order", bus.q, sb.pop_front());
      end
    end
    if (xfer) begin
      m_q   = din[g];
      m_qch = SELW'(g);
      m_qv  = 1'b1;
      sb.push_back(din[g]);
`ifdef MUX_RR_EN
      m_ptr = (g + 1) % NCH;
`endif
    end else if (m_qv && qr) begin
      m_qv = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

`ifndef MUX_RR_EN
  typedef struct {
    logic [NCH-1:0]   iv;
    logic [SELW-1:0]  sel;
    logic             qr;
    logic [WIDTH-1:0] d;
    logic [NCH-1:0]   exp_ir;
    logic             exp_qv;
    logic [WIDTH-1:0] exp_q;
    logic [SELW-1:0]  exp_qch;
  } vec_t;
  vec_t tbl[14];
`endif

  logic [31:0] rnd;

  initial begin
    reset_model();
    rst_n = 1'b0;
    drive(4'b1111, 2'd2, 1'b1, 16'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    check("rst_q", bus.q, 16'h0000);
    check("rst_qv", bus.qv, 1'b0);
    check("rst_qch", bus.qch, 2'd0);
    check("rst_ir", bus.ir, 4'b0000);
    rst_n = 1'b1;

`ifndef MUX_RR_EN
    tbl[0]  = '{4'b0100, 2'd2, 1'b1, 16'hBEEF, 4'b0100, 1'b1, 16'hBEEF, 2'd2};
    tbl[1]  = '{4'b0100, 2'd2, 1'b1, 16'h1234, 4'b0100, 1'b1, 16'h1234, 2'd2};
    tbl[2]  = '{4'b0100, 2'd2, 1'b0, 16'h5678, 4'b0000, 1'b1, 16'h1234, 2'd2};
    tbl[3]  = '{4'b0100, 2'd2, 1'b0, 16'h5678, 4'b0000, 1'b1, 16'h1234, 2'd2};
    tbl[4]  = '{4'b0010, 2'd1, 1'b0, 16'hAAAA, 4'b0000, 1'b1, 16'h1234, 2'd2};
    tbl[5]  = '{4'b0100, 2'd2, 1'b0, 16'h5678, 4'b0000, 1'b1, 16'h1234, 2'd2};
    tbl[6]  = '{4'b0100, 2'd2, 1'b0, 16'h5678, 4'b0000, 1'b1, 16'h1234, 2'd2};
    tbl[7]  = '{4'b0100, 2'd2, 1'b1, 16'h5678, 4'b0100, 1'b1, 16'h5678, 2'd2};
    tbl[8]  = '{4'b0000, 2'd2, 1'b1, 16'h9999, 4'b0100, 1'b0, 16'h5678, 2'd2};
    tbl[9]  = '{4'b0000, 2'd2, 1'b0, 16'h9999, 4'b0100, 1'b0, 16'h5678, 2'd2};
    tbl[10] = '{4'b0001, 2'd0, 1'b0, 16'h0F0F, 4'b0001, 1'b1, 16'h0F0F, 2'd0};
    tbl[11] = '{4'b1000, 2'd3, 1'b0, 16'h1111, 4'b0000, 1'b1, 16'h0F0F, 2'd0};
    tbl[12] = '{4'b1000, 2'd3, 1'b1, 16'h1111, 4'b1000, 1'b1, 16'h1111, 2'd3};
    tbl[13] = '{4'b0111, 2'd3, 1'b1, 16'h2222, 4'b1000, 1'b0, 16'h1111, 2'd3};
    for (int n = 0; n < 14; n++) begin
      drive(tbl[n].iv, tbl[n].sel, tbl[n].qr, tbl[n].d);
      step();
      check($sformatf("tbl%0d_ir", n), seen_ir, tbl[n].exp_ir);
      check($sformatf("tbl%0d_qv", n), bus.qv, tbl[n].exp_qv);
      check($sformatf("tbl%0d_q", n), bus.q, tbl[n].exp_q);
      check($sformatf("tbl%0d_qch", n), bus.qch, tbl[n].exp_qch);
    end
`else
    begin
      logic [SELW-1:0] exp_wrap [5];
      logic [SELW-1:0] exp_alt [3];
      exp_wrap = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      exp_alt  = '{2'd1, 2'd3, 2'd1};
      iv = 4'b1111;
      qr = 1'b1;
      for (int k = 0; k < NCH; k++) din[k] = WIDTH'(16'hA000 + k);
      for (int n = 0; n < 5; n++) begin
        step();
        check($sformatf("rr_wrap%0d_qch", n), bus.qch, exp_wrap[n]);
        check($sformatf("rr_wrap%0d_q", n), bus.q, 16'hA000 + 16'(exp_wrap[n]));
      end
      rst_n = 1'b0;
      iv    = '0;
      #3;
      rst_n = 1'b1;
      reset_model();
      iv = 4'b1010;
      qr = 1'b1;
      for (int n = 0; n < 3; n++) begin
        step();
        check($sformatf("rr_alt%0d_qch", n), bus.qch, exp_alt[n]);
      end
      qr = 1'b0;
      for (int n = 0; n < 3; n++) begin
        step();
        check($sformatf("rr_stall%0d_ir", n), seen_ir, 4'b0000);
        check($sformatf("rr_stall%0d_qch", n), bus.qch, 2'd1);
      end
      qr = 1'b1;
      step();
      check("rr_resume_qch", bus.qch, 2'd3);
    end
`endif

    // Reset in the middle of a held word must empty the slot before any clock edge.
    drive(4'b0100, 2'd2, 1'b0, 16'hCAFE);
    step();
    check("pre_rst_qv", bus.qv, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_qv", bus.qv, 1'b0);
    check("mid_rst_q", bus.q, 16'h0000);
    check("mid_rst_qch", bus.qch, 2'd0);
    check("mid_rst_ir", bus.ir, 4'b0000);
    iv = '0;
    #2;
    rst_n = 1'b1;
    reset_model();

    for (int n = 0; n < 400; n++) begin
      rnd = $urandom;
      iv  = rnd[NCH-1:0];
      sel = rnd[8+:SELW];
      qr  = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NCH; k++) din[k] = WIDTH'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_nx1_reg.md
MUX_NX1_REG -- requirements
Module: mux_nx1_reg

Interface
REQ-001 Parameter WIDTH, default 16: data bits per channel.
REQ-002 Parameter NCH, default 4: input channel count; the range is 2..16 and the value SHALL be a power of two. A localparam SELW = clog2(NCH) SHALL size the select and channel fields.
REQ-003 CLK  input  1: single clock; all state updates on the rising edge.
REQ-004 RST_N  input  1: reset, asynchronous, active-low.
REQ-005 I  input  NCH*WIDTH: packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-006 IV  input  NCH: per-channel valid.
REQ-007 IR  output  NCH: per-channel ready, combinational from state and inputs.
REQ-008 SEL  input  SELW: channel select, used in fixed-select mode.
REQ-009 Q  output  WIDTH: registered output data.
REQ-010 QV  output  1: output valid.
REQ-011 QR  input  1: downstream ready.
REQ-012 QCH  output  SELW: index of the channel that produced the current Q.

Function
REQ-013 A single output register slot SHALL hold Q/QCH; QV=1 means the slot is full.
REQ-014 Slot free this cycle: can_load = !QV | QR.
REQ-015 Channel transfer when IV[k] & IR[k]. Output transfer when QV & QR.
REQ-016 At most one IR bit SHALL be high in any cycle. IR[k] SHALL be high only if k is the granted channel and can_load=1.
REQ-017 On a channel-k transfer: Q <= I[k], QCH <= k and QV <= 1 at the next edge, giving 1-cycle latency.
REQ-018 If an output transfer occurs with no channel transfer, QV <= 0 at the next edge; Q and QCH SHALL hold their values.
REQ-019 Simultaneous output transfer and channel transfer: the slot reloads and QV stays 1, giving full throughput of one word per cycle.
REQ-020 QV=1 and QR=0: IR SHALL be all zero, and Q, QV and QCH SHALL hold stable.
REQ-021 Fixed-select mode: the granted channel = SEL, and IR[SEL] = can_load regardless of IV[SEL].
REQ-022 Changing SEL while QV=1 SHALL NOT alter Q or QCH.
REQ-023 No channel requesting (IV all zero, or IV[SEL]=0 in fixed mode): no load occurs and the slot drains per REQ-018.

Reset
REQ-024 While RST_N=0: Q=0, QV=0, QCH=0, round-robin pointer=0, and IR=0 SHALL be forced combinationally.
REQ-025 Reset asserted mid-transfer SHALL discard the slot contents immediately and asynchronously, without waiting for a clock edge.
REQ-026 After RST_N deasserts, the first load SHALL be possible at the first rising edge.

Configuration
REQ-027 Macro MUX_RR_EN selects round-robin arbitration.
REQ-028 With MUX_RR_EN defined: SEL SHALL be ignored, and the grant SHALL go to the first k with IV[k]=1, searching ptr, ptr+1, ... modulo NCH.
REQ-029 With MUX_RR_EN defined: on each channel transfer from channel g, ptr <= (g+1) mod NCH, wrapping from NCH-1 to 0. The pointer SHALL be unchanged when no channel transfer occurs, including when output back-pressure stalls the block.
REQ-030 With MUX_RR_EN undefined: fixed-select mode per REQ-021, with no pointer register present.

Verification
REQ-031 Reset: hold RST_N=0 with all IV=1 -> Q=0x0000, QV=0, QCH=0, IR=4'b0000. Assert RST_N mid-stream -> QV falls before the next edge.
REQ-032 Fixed mode, SEL=2, I[2]=0xBEEF, IV=4'b0100, QR=1 -> the edge after the transfer gives Q=0xBEEF, QCH=2, QV=1. Streaming then continues at 1 word/cycle.
REQ-033 Back-pressure: QV=1 with Q=0x1234, QR=0 for 5 cycles, new data on I[SEL] -> Q stays 0x1234 and IR=0 throughout. When QR rises, the new word loads on the same edge that the old word drains.
REQ-034 Drain: IV=0 and QR=1 after one word -> QV=0 on the next edge, and Q holds its last value.
REQ-035 MUX_RR_EN, NCH=4, IV=4'b1111, QR=1 constant -> QCH sequence 0,1,2,3,0 (pointer wrap).
REQ-036 MUX_RR_EN, IV=4'b1010 from ptr=0 -> grants 1,3,1. With QR=0 for 3 cycles, ptr holds and the next grant is unchanged.
